seq_demux: RTL and testbench
============================

# seq_demux

Registered, flow-controlled demultiplexer that routes a W-bit word on I to one of N output channels selected by S. Each channel has a one-entry holding slot with a valid/ready handshake, so producer and consumers can stall independently. It is the clocked successor to the combinational demux primitive and is used wherever a steered datapath needs back-pressure. An optional auto-increment mode sprays successive words round-robin across the channels.

## Interface
- W, 8, data width per channel (≥1)
- N, 4, number of output channels (2..64, need not be a power of two)
- INV, 0, 1 = output data is bitwise inverted on capture
- SW (localparam), clog2(N), select width
- CK  in  1  clock, rising edge
- CLR  in  1  reset; one clock, reset is asynchronous and active-high
- I  in  W  input data
- S  in  SW  channel select (ignored when AUTO=1)
- IV  in  1  input valid
- IR  out  1  input ready (combinational)
- Z  out  N*W  channel data, channel k at Z[k*W +: W]
- ZV  out  N  per-channel valid
- ZR  in  N  per-channel ready
- ERR  out  1  sticky out-of-range-select flag
- AUTO  in  1  auto-increment enable (only with SEQ_DEMUX_AUTOINC_EN)
- P  out  SW  round-robin pointer (only with SEQ_DEMUX_AUTOINC_EN)

## Operation
- Effective select sel = S, or P when AUTO=1 (macro build).
- Per-channel slot state: EMPTY (ZV[k]=0) / FULL (ZV[k]=1).
- Drain k: ZV[k] & ZR[k] at edge → slot goes EMPTY unless filled same edge.
- IR = (sel ≥ N) | ~ZV[sel] | ZR[sel].
- Accept: IV & IR & sel < N → slot[sel] captures I ^ {W{INV}}, ZV[sel] ← 1.
- Simultaneous drain and fill of same slot: slot stays FULL, holds new word; old word counts as consumed.
- sel ≥ N with IV=1: word accepted (IR=1) and discarded, ERR ← 1; ERR clears only on CLR.
- Non-selected slots hold data and valid unchanged; Z[k] stable while ZV[k]=1 and ZR[k]=0.
- Z[k] retains last captured value after drain (not zeroed).

## Timing
- Reset values (async, immediate on CLR high): ZV=0, Z=0, ERR=0, P=0. IR follows from cleared state (1 while CLR high, regardless of S).
- CLR asserted mid-transfer: all held words lost; no partial state survives.
- Latency: accepted word visible on Z/ZV one cycle after the accepting edge.
- Throughput: one word per cycle when target consumer keeps ZR high or targets rotate over empty slots.
- IR has a combinational path from S, AUTO, ZR; no path from I to IR.

## Configuration
- SEQ_DEMUX_AUTOINC_EN defined: AUTO input and P output exist. P advances (P+1) mod N on each accepted word while AUTO=1; wraps N-1→0 for non-power-of-two N; P holds while AUTO=0 or no accept. Since P < N always, AUTO=1 never raises ERR.
- Undefined: AUTO, P absent; sel = S always; no pointer register.

## Structure
- Package seq_demux_pkg: clog2 function, slot state encoding (EMPTY/FULL), default W/N constants.
- Sub-module seq_demux_slot: one channel's data register, valid bit, fill/drain logic; instantiated N times via generate. Top holds select decode, IR mux, ERR flag, pointer.

## Test plan
- W=8,N=4: S=2, I=8'hA5, IV=1, ZR=0 → next cycle ZV=4'b0100, Z[2]=8'hA5; second IV to S=2 sees IR=0 until ZR[2]=1.
- Fill ch1, hold ZR[1]=1 and stream I=1,2,3 to S=1 → one word/cycle, Z[1] sequence 1,2,3, ZV[1] stays 1.
- N=3: S=3, IV=1 → IR=1, ZV unchanged, ERR=1 and stays 1 until CLR.
- INV=1: I=8'h0F to S=0 → Z[0]=8'hF0.
- Auto build, N=3, AUTO=1, ZR=3'b111, five words 10..14 → channels 0,1,2,0,1 receive them; P=2 after.
- CLR pulse with ZV=4'b1111 → ZV=0, Z=0, P=0 immediately, before next CK edge.

Source files
------------

// File: rtl/seq_demux_pkg.sv
// Shared definitions for seq_demux: select-width helper, slot state encoding
// and default geometry.
package seq_demux_pkg;

  localparam int DEF_W = 8;
  localparam int DEF_N = 4;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_demux_slot.sv
// One output channel of seq_demux: a single-entry holding register with a
// valid/ready handshake toward its consumer.
module seq_demux_slot
  import seq_demux_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fill,
  input  logic         drain_rdy,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         vld
);

  slot_state_e  state_q, state_d;
  logic [W-1:0] data_q, data_d;

  // A fill on the same edge as a drain wins: the old word is consumed and
  // the new one takes its place without the slot ever going empty.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (fill) begin
      state_d = SLOT_FULL;
      data_d  = din;
    end else if (state_q == SLOT_FULL && drain_rdy) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign vld  = (state_q == SLOT_FULL);
  assign dout = data_q;

endmodule

// File: rtl/seq_demux.sv
// Registered, flow-controlled 1-to-N demultiplexer with per-channel holding slots.
// Define SEQ_DEMUX_AUTOINC_EN to add the AUTO input and round-robin pointer P.
module seq_demux
  import seq_demux_pkg::*;
#(
  parameter  int W   = DEF_W,
  parameter  int N   = DEF_N,
  parameter  int INV = 0,
  localparam int SW  = clog2(N)
) (
  input  logic           CK,
  input  logic           CLR,
  input  logic [W-1:0]   I,
  input  logic [SW-1:0]  S,
  input  logic           IV,
  output logic           IR,
  output logic [N*W-1:0] Z,
  output logic [N-1:0]   ZV,
  input  logic [N-1:0]   ZR,
  output logic           ERR
`ifdef SEQ_DEMUX_AUTOINC_EN
  ,
  input  logic           AUTO,
  output logic [SW-1:0]  P
`endif
);

  logic [SW-1:0] sel;
  logic [N-1:0]  hit;
  logic [N-1:0]  fill;
  logic          in_range;
  logic          accept;
  logic [W-1:0]  din;
  logic          err_q, err_d;

`ifdef SEQ_DEMUX_AUTOINC_EN
  logic [SW-1:0] p_q, p_d;

  always_comb begin
    sel = AUTO ? p_q : S;
  end
`else
  always_comb begin
    sel = S;
  end
`endif

  // One-hot decode; an all-zero hit vector marks a select beyond N-1.
  always_comb begin
    hit = '0;
    for (int k = 0; k < N; k++) hit[k] = (sel == SW'(k));
  end

  assign in_range = |hit;
  assign IR       = ~in_range | (|(hit & (~ZV | ZR)));
  assign accept   = IV & IR;
  assign fill     = accept ? hit : '0;
  assign din      = (INV != 0) ? ~I : I;

  always_comb begin
    err_d = err_q | (accept & ~in_range);
  end

  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign ERR = err_q;

`ifdef SEQ_DEMUX_AUTOINC_EN
  // Explicit wrap keeps the pointer inside 0..N-1 for non-power-of-two N.
  always_comb begin
    p_d = p_q;
    if (AUTO && accept) p_d = (p_q == SW'(N - 1)) ? '0 : p_q + 1'b1;
  end

  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) p_q <= '0;
    else     p_q <= p_d;
  end

  assign P = p_q;
`endif

  for (genvar k = 0; k < N; k++) begin : g_slot
    seq_demux_slot #(.W(W)) u_slot (
      .clk      (CK),
      .rst      (CLR),
      .fill     (fill[k]),
      .drain_rdy(ZR[k]),
      .din      (din),
      .dout     (Z[k*W +: W]),
      .vld      (ZV[k])
    );
  end

endmodule

// File: tb/tb_seq_demux.sv
// Self-checking bench for seq_demux: a W=8/N=4 instance and a W=8/N=3/INV=1
// instance, both checked against an array-based behavioural model.
module tb_seq_demux;

  logic        CK, CLR;
  logic [7:0]  i0, i1;
  logic [1:0]  s0, s1;
  logic        iv0, iv1;
  logic [3:0]  zr0;
  logic [2:0]  zr1;
  logic        ir0, ir1;
  logic [31:0] z0;
  logic [23:0] z1;
  logic [3:0]  zv0;
  logic [2:0]  zv1;
  logic        err0, err1;
  logic        auto0, auto1;
`ifdef SEQ_DEMUX_AUTOINC_EN
  logic [1:0]  p0, p1;
`endif

  int n_cmp, n_bad;

  bit         m_full [2][4];
  logic [7:0] m_data [2][4];
  bit         m_err  [2];
  int         m_p    [2];

  seq_demux #(.W(8), .N(4), .INV(0)) u_dut0 (
    .CK(CK), .CLR(CLR), .I(i0), .S(s0), .IV(iv0), .IR(ir0),
    .Z(z0), .ZV(zv0), .ZR(zr0), .ERR(err0)
`ifdef SEQ_DEMUX_AUTOINC_EN
    , .AUTO(auto0), .P(p0)
`endif
  );

  seq_demux #(.W(8), .N(3), .INV(1)) u_dut1 (
    .CK(CK), .CLR(CLR), .I(i1), .S(s1), .IV(iv1), .IR(ir1),
    .Z(z1), .ZV(zv1), .ZR(zr1), .ERR(err1)
`ifdef SEQ_DEMUX_AUTOINC_EN
    , .AUTO(auto1), .P(p1)
`endif
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  function automatic int nof(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int eff_sel(input int d, input logic [1:0] s, input logic au);
    return au ? m_p[d] : int'(s);
  endfunction

  function automatic bit exp_ir(input int d, input int sel, input logic [3:0] zr);
    if (sel >= nof(d)) return 1'b1;
    return !m_full[d][sel] || zr[sel];
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) begin
        m_full[d][k] = 1'b0;
        m_data[d][k] = 8'h00;
      end
      m_err[d] = 1'b0;
      m_p[d]   = 0;
    end
  endfunction

  function automatic void model_edge(input int d, input logic [1:0] s, input logic iv,
                                     input logic [3:0] zr, input logic [7:0] i,
                                     input logic au);
    int sel;
    bit ir;
    sel = eff_sel(d, s, au);
    ir  = exp_ir(d, sel, zr);
    for (int k = 0; k < nof(d); k++)
      if (m_full[d][k] && zr[k]) m_full[d][k] = 1'b0;
    if (iv && ir) begin
      if (sel < nof(d)) begin
        m_full[d][sel] = 1'b1;
        m_data[d][sel] = (d == 1) ? ~i : i;
      end else begin
        m_err[d] = 1'b1;
      end
      if (au) m_p[d] = (m_p[d] + 1) % nof(d);
    end
  endfunction

  function automatic logic [31:0] exp_z(input int d);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < nof(d); k++) v[k*8 +: 8] = m_data[d][k];
    return v;
  endfunction

  function automatic logic [31:0] exp_zv(input int d);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < nof(d); k++) v[k] = m_full[d][k];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ir_all();
    chk("ir0", 32'(ir0), 32'(exp_ir(0, eff_sel(0, s0, auto0), zr0)));
    chk("ir1", 32'(ir1), 32'(exp_ir(1, eff_sel(1, s1, auto1), {1'b0, zr1})));
  endtask

  task automatic check_outs();
    chk("zv0", 32'(zv0), exp_zv(0));
    chk("z0", z0, exp_z(0));
    chk("err0", 32'(err0), 32'(m_err[0]));
    chk("zv1", 32'(zv1), exp_zv(1));
    chk("z1", 32'(z1), exp_z(1));
    chk("err1", 32'(err1), 32'(m_err[1]));
`ifdef SEQ_DEMUX_AUTOINC_EN
    chk("p0", 32'(p0), 32'(m_p[0]));
    chk("p1", 32'(p1), 32'(m_p[1]));
`endif
  endtask

  task automatic tick();
    #1;
    check_ir_all();
    @(posedge CK);
    model_edge(0, s0, iv0, zr0, i0, auto0);
    model_edge(1, s1, iv1, {1'b0, zr1}, i1, auto1);
    #1;
    check_outs();
  endtask

  task automatic do_reset();
    CLR = 1'b1;
    model_clear();
    #1;
    check_ir_all();
    check_outs();
    @(posedge CK);
    #1;
    CLR = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    CLR = 1'b0;
    i0 = '0; i1 = '0; s0 = '0; s1 = '0; iv0 = 1'b0; iv1 = 1'b0;
    zr0 = '0; zr1 = '0; auto0 = 1'b0; auto1 = 1'b0;
    model_clear();
    #2;
    do_reset();

    // Capture into ch2, then back-pressure, then simultaneous drain and fill.
    s0 = 2'd2; i0 = 8'hA5; iv0 = 1'b1; zr0 = 4'b0000;
    tick();
    chk("z2_a5", 32'(z0[23:16]), 32'hA5);
    chk("zv_0100", 32'(zv0), 32'h4);
    i0 = 8'h5A;
    tick();
    chk("ir_blocked", 32'(ir0), 32'h0);
    zr0 = 4'b0100;
    tick();
    chk("z2_5a", 32'(z0[23:16]), 32'h5A);

    // Stream into ch1 with its consumer always ready.
    s0 = 2'd1; zr0 = 4'b0010;
    for (int n = 1; n <= 3; n++) begin
      i0 = 8'(n);
      tick();
      chk("stream_z1", 32'(z0[15:8]), 32'(n));
      chk("stream_zv1", 32'(zv0[1]), 32'h1);
    end
    iv0 = 1'b0;
    tick();
    chk("drained_zv1", 32'(zv0[1]), 32'h0);
    chk("retained_z1", 32'(z0[15:8]), 32'h3);

    // Out-of-range select on N=3: accepted, discarded, sticky error.
    s1 = 2'd3; i1 = 8'h77; iv1 = 1'b1;
    #1;
    chk("ir_oor", 32'(ir1), 32'h1);
    tick();
    chk("err_set", 32'(err1), 32'h1);
    chk("zv_oor", 32'(zv1), 32'h0);
    iv1 = 1'b0; s1 = 2'd0;
    repeat (3) tick();
    chk("err_sticky", 32'(err1), 32'h1);

    // Inverting instance.
    s1 = 2'd0; i1 = 8'h0F; iv1 = 1'b1; zr1 = 3'b000;
    tick();
    chk("inv_z0", 32'(z1[7:0]), 32'hF0);
    iv1 = 1'b0;

    // Fill every channel of dut0, then reset mid-transfer.
    zr0 = 4'b0000; iv0 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      s0 = 2'(c); i0 = 8'h10 + 8'(c);
      tick();
    end
    iv0 = 1'b0;
    chk("all_full", 32'(zv0), 32'hF);
    s0 = 2'd3;
    do_reset();
    tick();

`ifdef SEQ_DEMUX_AUTOINC_EN
    auto1 = 1'b1; zr1 = 3'b111; iv1 = 1'b1;
    for (int n = 0; n < 5; n++) begin
      i1 = 8'(10 + n);
      tick();
    end
    iv1 = 1'b0; auto1 = 1'b0;
    chk("p_after", 32'(p1), 32'h2);
    tick();
`endif

    do_reset();
    repeat (400) begin
      i0  = 8'($urandom);
      s0  = 2'($urandom_range(0, 3));
      iv0 = ($urandom_range(0, 3) != 0);
      zr0 = 4'($urandom);
      i1  = 8'($urandom);
      s1  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      iv1 = ($urandom_range(0, 3) != 0);
      zr1 = 3'($urandom);
`ifdef SEQ_DEMUX_AUTOINC_EN
      auto0 = ($urandom_range(0, 2) == 0);
      auto1 = ($urandom_range(0, 2) == 0);
`endif
      tick();
    end
    auto0 = 1'b0; auto1 = 1'b0; iv0 = 1'b0; iv1 = 1'b0;
    do_reset();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
